// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: accepts a byte over valid/ready, then shifts it
// out on txd as start bit, DATA_W data bits LSB first, and a stop bit.
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   // Handshake: a byte is taken on a rising edge where tx_valid and tx_ready
   // are both high; tx_ready is high only in IDLE, so tx_valid is ignored
   // while a frame is in flight and a held tx_valid waits for the next IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state, state_next;
   logic [BAUD_W-1:0]   baud_cnt, baud_next;
   logic [BIT_W-1:0]    bit_cnt, bit_next;
   logic [DATA_W-1:0]   shreg, shreg_next;
   logic                txd_q, txd_next;
   logic                baud_done;

   assign baud_done = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shreg    <= shreg_next;
         txd_q    <= txd_next;
      end
   end

   // txd_next is the line level for the state being entered, so txd is a
   // pure register and the first cycle of every bit already shows its value.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shreg_next = shreg;
      txd_next   = txd_q;
      case (state)
         IDLE: begin
            txd_next = 1'b1;
            if (tx_valid) begin
               state_next = START;
               shreg_next = tx_data;
               baud_next  = '0;
               bit_next   = '0;
               txd_next   = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = DATA;
               txd_next   = shreg[0];
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next  = '0;
               shreg_next = shreg >> 1;
               bit_next   = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  txd_next = shreg_next[0];
               end
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = IDLE;
               txd_next   = 1'b1;
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   assign txd      = txd_q;
   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one instance at 4 clocks per bit, one at 1 clock
// per bit; expected line levels are queued when a byte is driven.
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data4, data1;
   logic       valid4, valid1;
   logic       ready4, ready1;
   logic       txd4, txd1;
   logic       busy4, busy1;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];
   logic [0:0] exp_bit;

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst(rst), .tx_data(data4), .tx_valid(valid4),
      .tx_ready(ready4), .txd(txd4), .busy(busy4)
   );

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
      .tx_ready(ready1), .txd(txd1), .busy(busy1)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // driver tasks
   task automatic push_frame(input logic [7:0] d);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      exp_q.push_back(1'b1);
   endtask

   // Offers d at a falling edge; the next rising edge is the handshake edge.
   task automatic drive_byte4(input logic [7:0] d, input bit hold);
      @(negedge clk);
      data4  = d;
      valid4 = 1'b1;
      push_frame(d);
      @(posedge clk);
      #1;
      if (!hold) valid4 = 1'b0;
   endtask

   task automatic pop_exp(input string name);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue: expected queue empty, required a pending bit", name);
         exp_bit = 1'b1;
      end else begin
         exp_bit = exp_q.pop_front();
      end
   endtask

   // scenarios
   task automatic test_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({txd4, ready4, busy4, txd1, ready1, busy1} !== 6'b110110) begin
         errors++;
         $display("FAIL reset_async: got %b required 110110",
                  {txd4, ready4, busy4, txd1, ready1, busy1});
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({txd4, ready4, busy4, txd1, ready1, busy1} !== 6'b110110) begin
         errors++;
         $display("FAIL reset_release: got %b required 110110",
                  {txd4, ready4, busy4, txd1, ready1, busy1});
      end
   endtask

   task automatic test_single_frame();
      drive_byte4(8'hA5, 1'b0);
      for (int s = 0; s < 10; s++) begin
         pop_exp("single");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0] || busy4 !== 1'b1 || ready4 !== 1'b0) begin
               errors++;
               $display("FAIL single slot%0d cyc%0d: txd=%b busy=%b ready=%b required txd=%b busy=1 ready=0",
                        s, c, txd4, busy4, ready4, exp_bit[0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b1 || busy4 !== 1'b0 || txd4 !== 1'b1) begin
         errors++;
         $display("FAIL single_end cycle41: ready=%b busy=%b txd=%b required 1 0 1",
                  ready4, busy4, txd4);
      end
   endtask

   task automatic test_back_to_back();
      drive_byte4(8'h3C, 1'b1);
      data4 = 8'hFF;
      push_frame(8'hFF);
      for (int s = 0; s < 10; s++) begin
         pop_exp("b2b_first");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0] || ready4 !== 1'b0) begin
               errors++;
               $display("FAIL b2b_first slot%0d cyc%0d: txd=%b ready=%b required txd=%b ready=0",
                        s, c, txd4, ready4, exp_bit[0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready cycle41: ready=%b required 1", ready4);
      end
      @(posedge clk);
      #1 valid4 = 1'b0;
      for (int s = 0; s < 10; s++) begin
         pop_exp("b2b_second");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0] || busy4 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_second slot%0d cyc%0d: txd=%b busy=%b required txd=%b busy=1",
                        s, c, txd4, busy4, exp_bit[0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b1 || busy4 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: ready=%b busy=%b required 1 0", ready4, busy4);
      end
   endtask

   task automatic test_input_stability();
      drive_byte4(8'h00, 1'b0);
      data4  = 8'hFF;
      valid4 = 1'b1;
      for (int s = 0; s < 10; s++) begin
         pop_exp("stable");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0] || ready4 !== 1'b0) begin
               errors++;
               $display("FAIL stable slot%0d cyc%0d: txd=%b ready=%b required txd=%b ready=0",
                        s, c, txd4, ready4, exp_bit[0]);
            end
         end
      end
      valid4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b1 || busy4 !== 1'b0 || txd4 !== 1'b1) begin
         errors++;
         $display("FAIL stable_no_capture: ready=%b busy=%b txd=%b required 1 0 1",
                  ready4, busy4, txd4);
      end
   endtask

   task automatic test_reset_mid_frame();
      drive_byte4(8'h00, 1'b0);
      for (int s = 0; s < 4; s++) begin
         pop_exp("abort_pre");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0]) begin
               errors++;
               $display("FAIL abort_pre slot%0d cyc%0d: txd=%b required %b",
                        s, c, txd4, exp_bit[0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (txd4 !== 1'b0 || busy4 !== 1'b1) begin
         errors++;
         $display("FAIL abort_bit3: txd=%b busy=%b required 0 1", txd4, busy4);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (txd4 !== 1'b1 || ready4 !== 1'b1 || busy4 !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: txd=%b ready=%b busy=%b required 1 1 0",
                  txd4, ready4, busy4);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      drive_byte4(8'h81, 1'b0);
      for (int s = 0; s < 10; s++) begin
         pop_exp("abort_post");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0] || busy4 !== 1'b1) begin
               errors++;
               $display("FAIL abort_post slot%0d cyc%0d: txd=%b busy=%b required txd=%b busy=1",
                        s, c, txd4, busy4, exp_bit[0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b1) begin
         errors++;
         $display("FAIL abort_post_end: ready=%b required 1", ready4);
      end
   endtask

   task automatic test_one_clk_per_bit();
      @(negedge clk);
      data1  = 8'h01;
      valid1 = 1'b1;
      push_frame(8'h01);
      @(posedge clk);
      #1 valid1 = 1'b0;
      for (int s = 0; s < 10; s++) begin
         pop_exp("cpb1");
         @(negedge clk);
         checks++;
         if (txd1 !== exp_bit[0] || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL cpb1 cycle%0d: txd=%b busy=%b required txd=%b busy=1",
                     s + 1, txd1, busy1, exp_bit[0]);
         end
      end
      @(negedge clk);
      checks++;
      if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL cpb1_end cycle11: ready=%b busy=%b required 1 0", ready1, busy1);
      end
   endtask

   // A randomly chosen byte with a random idle gap, as a final sanity frame.
   task automatic test_random_frame();
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      drive_byte4(d, 1'b0);
      for (int s = 0; s < 10; s++) begin
         pop_exp("random");
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (txd4 !== exp_bit[0]) begin
               errors++;
               $display("FAIL random d=%h slot%0d cyc%0d: txd=%b required %b",
                        d, s, c, txd4, exp_bit[0]);
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      data4  = '0;
      data1  = '0;
      valid4 = 1'b0;
      valid1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      test_reset();
      test_single_frame();
      test_back_to_back();
      test_input_stability();
      test_reset_mid_frame();
      test_one_clk_per_bit();
      test_random_frame();

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-in, serial-out frame transmitter. It loads a byte through a valid/ready handshake into an internal shift register, then drives it out on one line as a UART-style frame: start bit, data bits LSB first, stop bit. It is the transmit side of the byte-register datapath and feeds a serial link or a matching receiver.

Parameters:
DATA_W, 8, number of data bits per frame (at least 1)
CLKS_PER_BIT, 4, clock cycles each bit is held on txd (at least 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
tx_data  input  DATA_W  byte to transmit; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte (IDLE only)
txd  output  1  serial line, idles high; driven from a register
busy  output  1  frame in progress (inverse of tx_ready)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- While rst=1, regardless of clk: txd=1, tx_ready=1, busy=0, state IDLE, shift register and counters cleared.
- States and transitions:
  - IDLE: txd=1, tx_ready=1. Handshake occurs when tx_valid=1 and tx_ready=1 at a rising edge. On that edge: capture tx_data into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd = shreg[0], held CLKS_PER_BIT cycles per bit. After each bit, shift right and increment the bit counter. After DATA_W bits, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT), minimum 1.
  - Reloads to 0 on every bit boundary and on handshake.
- Bit counter: width $clog2(DATA_W+1).
- Timing (handshake edge = cycle 0):
  - txd=0 in cycles 1..CLKS_PER_BIT.
  - Data bit k occupies cycles (k+1)*CLKS_PER_BIT+1 .. (k+2)*CLKS_PER_BIT.
  - Stop bit ends at cycle N = (DATA_W+2)*CLKS_PER_BIT.
  - tx_ready=1 again from cycle N+1.
  - Minimum accept-to-accept spacing is N+1 cycles.
- busy=1 from cycle 1 through cycle N inclusive.
- tx_valid while busy: ignored, no capture. A source holding tx_valid is accepted at the first IDLE edge.
- Changes on tx_data after the handshake do not affect the frame in flight.
- Reset asserted mid-frame: frame aborted, txd goes to 1 immediately. After release, IDLE with tx_ready=1; there is no partial resume.
- No combinational path from inputs to txd. tx_ready and busy are decoded from the state register only.

Test Plan:
- Reset check: assert rst mid-cycle with no clk edge -> txd=1, tx_ready=1, busy=0 immediately; hold 3 cycles; release -> outputs unchanged.
- Single frame, tx_data=0xA5, CLKS_PER_BIT=4, one-cycle valid pulse -> txd per 4-cycle bit slot = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy high cycles 1..40; tx_ready=1 at cycle 41.
- Held valid, back-to-back: tx_valid held with 0x3C then 0xFF -> second accept exactly at cycle 41; second frame bit slots = 0,0,0,1,1,1,1,0,0,1 followed by 0,1,1,1,1,1,1,1,1,1.
- Input stability: after accepting 0x00, drive tx_data=0xFF with tx_valid=1 during the frame -> all data slots 0, no second capture until tx_ready=1.
- Reset mid-frame: assert rst in data bit 3 of a 0x00 frame -> txd=1 within the same cycle. After release, new 0x81 frame is correct from its own start bit.
- CLKS_PER_BIT=1, DATA_W=8, tx_data=0x01 -> txd = 0,1,0,0,0,0,0,0,0,1 on consecutive cycles 1..10; tx_ready=1 at cycle 11.
